// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and byte-lane helper for the load/store data memory
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        lane_mask = funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    funct3[1:0] == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store data replication, load extension and access-fault flags
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = raw[{addr_lo, 3'b000} +: 8];
        h          = addr_lo[1] ? raw[31:16] : raw[15:0];
        be         = lane_mask(funct3, addr_lo);
        wdata_sh   = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        rdata_ext  = funct3 == F3_B  ? {{24{b[7]}}, b} :
                     funct3 == F3_BU ? {24'b0, b} :
                     funct3 == F3_H  ? {{16{h[15]}}, h} :
                     funct3 == F3_HU ? {16'b0, h} : raw;
        misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
        illegal    = we ? funct3 >= 3'b011 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    end

endmodule

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: RV32I byte-lane data memory with fault detection, configurable read latency and reset sweep
module lsu_data_memory
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int READ_LAT   = 1,
    parameter bit INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int                DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-3:0] LAST     = '1;
    localparam logic [1:0]        LAT_LAST = 2'(READ_LAT > 1 ? READ_LAT - 2 : 0);

    logic [31:0]       mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-3:0] cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [31:0]       pend_data_q, pend_data_d, rsp_rdata_q, rsp_rdata_d;
    logic              pend_err_q, pend_err_d, rsp_err_q, rsp_err_d;
    logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic              accept, err, mem_we, misaligned, illegal;
    logic [3:0]        be;
    logic [31:0]       raw, wword, wdata_sh, rdata_ext;
    logic [ADDR_W-3:0] idx;

    assign idx = req_addr[ADDR_W-1:2];
    assign raw = mem[idx];

    lsu_align u_align (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .raw        (raw),
        .be         (be),
        .wdata_sh   (wdata_sh),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_comb begin
        accept      = req_valid && req_ready_q;
        err         = misaligned || illegal || req_addr[31:ADDR_W] != '0;
        mem_we      = accept && req_we && !err;
        wword       = raw;
        for (int i = 0; i < 4; i++) wword[8*i +: 8] = be[i] ? wdata_sh[8*i +: 8] : raw[8*i +: 8];
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        case (state_q)
            INIT: begin
                cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
                state_d = cnt_q == LAST ? IDLE : INIT;
            end
            IDLE: if (accept) begin
                state_d     = READ_LAT > 1 ? WAIT : RESP;
                lat_d       = '0;
                pend_data_d = err || req_we ? '0 : rdata_ext;
                pend_err_d  = err;
            end
            WAIT: begin
                lat_d   = lat_q + 1'b1;
                state_d = lat_q == LAT_LAST ? RESP : WAIT;
            end
            default: state_d = rsp_ready ? IDLE : RESP;
        endcase
        // Response registers load straight from the next pending value so READ_LAT=1 needs no extra stage.
        req_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
        rsp_valid_d = state_d == RESP;
        rsp_rdata_d = state_d == RESP ? pend_data_d : '0;
        rsp_err_d   = state_d == RESP ? pend_err_d : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_CLEAR ? INIT : IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= INIT_CLEAR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) mem[cnt_q] <= '0;
        else if (mem_we) mem[idx] <= wword;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// tb_lsu_data_memory: directed table, handshake corner cases and random traffic against a byte-array model
module tb_lsu_data_memory;

    localparam int AW  = 8;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int passed = 0;
    int total  = 0;

    logic [7:0] m [2**AW];
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] xr;
        logic        xe;
    } vec_t;

    vec_t tbl [$];

    lsu_data_memory #(.ADDR_W(AW), .READ_LAT(LAT), .INIT_CLEAR(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Byte-addressed reference: sizes, alignment, range and funct3 legality from the ISA rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int sz;
        logic [31:0] v;
        sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        e  = (we ? f3 >= 3'd3 : (f3 == 3'd3 || f3 >= 3'd6)) || a >= 2**AW || a % sz != 0;
        rd = '0;
        v  = '0;
        if (!e) for (int k = 0; k < sz; k++) if (we) m[a + k] = wd[8*k +: 8]; else v[8*k +: 8] = m[a + k];
        if (!e && !we) rd = f3 == 3'd0 ? {{24{v[7]}}, v[7:0]} : f3 == 3'd1 ? {{16{v[15]}}, v[15:0]} : v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2**AW; i++) m[i] = 8'h00;
    endtask

    task automatic init_check(input string nm);
        bit bad = 0;
        for (int i = 0; i < 64; i++) begin
            bad |= !busy || req_ready;
            @(negedge clk);
        end
        chk({nm, " init_busy"}, 32'(bad), 32'd0);
        chk({nm, " init_done"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] xr, input logic xe, input int hold, input string nm);
        int n = 0;
        bit bad = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk({nm, " ready"}, 32'(req_ready), 32'd1);
        rsp_ready  = hold == 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 10) begin bad |= req_ready; @(negedge clk); n++; end
        chk({nm, " lat"}, 32'(n), 32'(LAT));
        chk({nm, " ready_low"}, 32'(bad), 32'd0);
        chk({nm, " rdata"}, rsp_rdata, xr);
        chk({nm, " err"}, 32'(rsp_err), 32'(xe));
        if (hold > 0) begin
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                bad |= !rsp_valid || req_ready || rsp_rdata !== xr || rsp_err !== xe;
            end
            chk({nm, " hold"}, 32'(bad), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, " release"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic        we, xe;
        logic [2:0]  f3;
        logic [31:0] a, wd, xr;
        tbl = '{
            '{1'b0, 3'd2, 32'h3C,  32'h0,        32'h0,         1'b0},
            '{1'b1, 3'd2, 32'h10,  32'h8070F0FF, 32'h0,         1'b0},
            '{1'b0, 3'd0, 32'h10,  32'h0,        32'hFFFFFFFF,  1'b0},
            '{1'b0, 3'd4, 32'h11,  32'h0,        32'h000000F0,  1'b0},
            '{1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFF8070,  1'b0},
            '{1'b0, 3'd5, 32'h12,  32'h0,        32'h00008070,  1'b0},
            '{1'b1, 3'd2, 32'h20,  32'h11223344, 32'h0,         1'b0},
            '{1'b1, 3'd0, 32'h21,  32'h000000AB, 32'h0,         1'b0},
            '{1'b0, 3'd2, 32'h20,  32'h0,        32'h1122AB44,  1'b0},
            '{1'b1, 3'd1, 32'h22,  32'h0000BEEF, 32'h0,         1'b0},
            '{1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEFAB44,  1'b0},
            '{1'b0, 3'd2, 32'h06,  32'h0,        32'h0,         1'b1},
            '{1'b0, 3'd2, 32'h04,  32'h0,        32'h0,         1'b0},
            '{1'b1, 3'd1, 32'h05,  32'h0000FFFF, 32'h0,         1'b1},
            '{1'b0, 3'd2, 32'h04,  32'h0,        32'h0,         1'b0},
            '{1'b0, 3'd1, 32'h100, 32'h0,        32'h0,         1'b1},
            '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,         1'b1},
            '{1'b0, 3'd2, 32'h10,  32'h0,        32'h8070F0FF,  1'b0},
            '{1'b1, 3'd3, 32'h40,  32'hDEADBEEF, 32'h0,         1'b1},
            '{1'b0, 3'd2, 32'h40,  32'h0,        32'h0,         1'b0},
            '{1'b1, 3'd2, 32'h100, 32'hCAFEF00D, 32'h0,         1'b1},
            '{1'b0, 3'd2, 32'h00,  32'h0,        32'h0,         1'b0},
            '{1'b1, 3'd0, 32'h13,  32'h00000055, 32'h0,         1'b0},
            '{1'b0, 3'd2, 32'h10,  32'h0,        32'h5570F0FF,  1'b0},
            '{1'b0, 3'd0, 32'h12,  32'h0,        32'h00000070,  1'b0},
            '{1'b1, 3'd1, 32'h02,  32'h00012345, 32'h0,         1'b0},
            '{1'b0, 3'd2, 32'h00,  32'h0,        32'h23450000,  1'b0}
        };
        clear_model();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outs", {rsp_valid, req_ready, rsp_err, busy, rsp_rdata[27:0]}, 32'h1000_0000);
        rst = 1'b0;
        init_check("boot");

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, xr, xe);
            xact(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].xr, tbl[i].xe, 0, $sformatf("vec%0d", i));
        end

        model(1'b0, 3'd2, 32'h20, 32'h0, xr, xe);
        xact(1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0, 5, "held");

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            a  = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            wd = $urandom;
            model(we, f3, a, wd, xr, xe);
            xact(we, f3, a, wd, xr, xe, $urandom_range(0, 5) == 0 ? $urandom_range(1, 3) : 0, $sformatf("rnd%0d", i));
        end

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_wait", {29'd0, rsp_valid, req_ready, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        init_check("rst_wait");
        xact(1'b0, 3'd2, 32'h30, 32'h0, 32'h0, 1'b0, 0, "after_rst");

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h30;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("rst_resp up", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1 chk("rst_resp drop", {30'd0, rsp_valid, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        init_check("rst_resp");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
